hdr_rr_arbiter: RTL and testbench
=================================

// Module: hdr_rr_arbiter
// PURPOSE
//  Round-robin arbiter that drains NUM_PROCS per-processor header latches into one registered output stage.
//  Sits between the parallel header-processor latches and the shared downstream consumer (output queue writer).
//  Issues one read pulse per grant, captures the header and out_port mask, then presents them with valid/ready.
//  Sustains one header per cycle when ready_i is held high.
// PARAMETERS
//  NUM_PROCS  4                              number of source latches; legal range >= 2
//  ID_W       $clog2(NUM_PROCS)              width of src_id_o
// PORTS
//  clk         in   1                        clock
//  rst         in   1                        synchronous, active-high reset
//  empty_i     in   NUM_PROCS                per-latch empty flag; bit k = latch k holds nothing
//  pkt_hdr_i   in   [0:NUM_PROCS-1][0:`HDR_MAX_LEN-1] x `BYTE_BUS   per-latch header bytes
//  out_port_i  in   [0:NUM_PROCS-1] x `NUM_PORTS                    per-latch egress port mask
//  rd_o        out  NUM_PROCS                one-hot read pulse to the granted latch (combinational)
//  valid_o     out  1                        output stage holds a header
//  ready_i     in   1                        consumer accepts the header this cycle
//  pkt_hdr_o   out  [0:`HDR_MAX_LEN-1] x `BYTE_BUS                  registered header
//  out_port_o  out  `NUM_PORTS               registered port mask
//  src_id_o    out  ID_W                     index of the latch the header came from
//  drop_cnt_o  out  16                       dropped-header count (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//   - Outputs: valid_o=0, pkt_hdr_o all `ZERO_BYTE, out_port_o=0, src_id_o=0, drop_cnt_o=0.
//   - Internal: rr pointer ptr=0.
//   - rd_o is forced to 0 during any cycle in which rst=1.
//  Stage free:
//   - free = !valid_o || ready_i.
//   - A grant is issued only when free=1 and at least one bit of empty_i is 0.
//  Winner selection:
//   - Winner g = first k with empty_i[k]=0, searching ptr, ptr+1, ... with wrap mod NUM_PROCS.
//  Grant cycle t:
//   - rd_o = one-hot(g).
//   - At edge t+1: pkt_hdr_o <= pkt_hdr_i[g], out_port_o <= out_port_i[g], src_id_o <= g, valid_o <= 1.
//   - Pointer update: ptr <= (g == NUM_PROCS-1) ? 0 : g+1.
//   - Latency from a latch going non-empty to valid_o: 1 cycle.
//  No grant while free:
//   - Applies when free=1 but every latch is empty.
//   - If ready_i=1, valid_o <= 0 at the next edge.
//   - Header, out_port and src_id registers hold their values; they are not zeroed.
//  Backpressure:
//   - While valid_o=1 and ready_i=0: rd_o=0 and all output registers hold.
//   - Pointer holds.
//  Simultaneous accept and grant:
//   - When valid_o=1, ready_i=1 and a latch is non-empty, the new header replaces the old one at the same edge.
//   - No bubble is inserted.
//  Double-read safety:
//   - A source latch reports empty the cycle after its read pulse.
//   - The arbiter relies on this and never pulses the same latch on two consecutive cycles unless empty_i says it is refilled.
//  Reset mid-operation:
//   - The pending header in the output stage is discarded; no rd_o is issued in the reset cycle.
// CONFIGURATION
//  Macro HDR_ARB_DROP_EN.
//  Defined:
//   - A winner whose out_port_i[g]==0 is still read: rd_o pulses and ptr advances as for a normal grant.
//   - The output stage is not loaded; valid_o <= 0 if ready_i=1, otherwise valid_o holds.
//   - drop_cnt_o increments by 1 and saturates at 16'hFFFF.
//   - A drop grant obeys the same free=1 requirement as a normal grant.
//  Undefined:
//   - Zero-mask headers are forwarded like any other header.
//   - drop_cnt_o is tied to 0.
// TESTING
//  T1 Reset:
//   - Stimulus: hold rst=1 with empty_i=4'b0000 and ready_i=1.
//   - Required: rd_o=0 every cycle; all outputs at reset values; first grant after release goes to latch 0.
//  T2 Single source:
//   - Stimulus: empty_i=4'b1011, out_port_i[2]=8'h04, ready_i=1.
//   - Required: rd_o=4'b0100 in cycle t; at t+1 valid_o=1, src_id_o=2, out_port_o=8'h04.
//  T3 Fairness:
//   - Stimulus: all four latches kept full by a refill model, ready_i=1.
//   - Required: src_id_o sequence 0,1,2,3,0,1; exactly one rd_o bit per cycle.
//  T4 Backpressure:
//   - Stimulus: valid_o=1, ready_i=0 for 5 cycles, latches 1 and 3 full.
//   - Required: rd_o=0 and outputs stable throughout.
//   - Then: ready_i=1 -> same-cycle grant to the next rr winner, new header visible at the following edge.
//  T5 Drop (HDR_ARB_DROP_EN):
//   - Stimulus: latch 1 only, out_port_i[1]=0.
//   - Required: rd_o=4'b0010; valid_o stays 0; drop_cnt_o=1.
//   - Without the macro: valid_o=1, src_id_o=1, out_port_o=0.
//  T6 Mid-op reset:
//   - Stimulus: rst=1 for one cycle while valid_o=1, ready_i=0.
//   - Required: valid_o=0 next cycle, ptr=0, no rd_o pulse in the rst cycle.

Source files
------------

// File: rtl/hdr_rr_arbiter.sv
// hdr_rr_arbiter
//  Drains NUM_PROCS per-processor header latches into one registered output
//  stage. The source is picked round-robin. Each grant produces a single read
//  pulse. The captured header and port mask are presented with valid/ready,
//  and the block sustains one header per cycle while ready_i stays high.
//
//  Optional feature macro: HDR_ARB_DROP_EN.
//   Defined   : a winner with an all-zero port mask is still read, but it is
//               not forwarded, and drop_cnt_o counts it (saturating).
//   Undefined : zero-mask headers are forwarded normally; drop_cnt_o is 0.

`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 4
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef NUM_PORTS
`define NUM_PORTS 8
`endif
`ifndef ZERO_BYTE
`define ZERO_BYTE {`BYTE_BUS{1'b0}}
`endif

module hdr_rr_arbiter #(
    parameter int NUM_PROCS = 4,
    parameter int ID_W      = $clog2(NUM_PROCS)
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_PROCS-1:0]                               empty_i,
    input  logic [0:NUM_PROCS-1][0:`HDR_MAX_LEN-1][`BYTE_BUS-1:0] pkt_hdr_i,
    input  logic [0:NUM_PROCS-1][`NUM_PORTS-1:0]               out_port_i,
    output logic [NUM_PROCS-1:0]                               rd_o,
    output logic                                               valid_o,
    input  logic                                               ready_i,
    output logic [0:`HDR_MAX_LEN-1][`BYTE_BUS-1:0]             pkt_hdr_o,
    output logic [`NUM_PORTS-1:0]                              out_port_o,
    output logic [ID_W-1:0]                                    src_id_o,
    output logic [15:0]                                        drop_cnt_o
);

    localparam logic [ID_W:0] NP_W = (ID_W+1)'(NUM_PROCS);

    logic [ID_W-1:0]                           ptr_r;
    logic                                      valid_r;
    logic [0:`HDR_MAX_LEN-1][`BYTE_BUS-1:0]    pkt_hdr_r;
    logic [`NUM_PORTS-1:0]                     out_port_r;
    logic [ID_W-1:0]                           src_id_r;

    logic                                      free_s;
    logic                                      found_s;
    logic [ID_W-1:0]                           win_s;
    logic [ID_W:0]                             cand_s;
    logic                                      grant_s;
    logic                                      drop_s;
    logic                                      load_s;

    // The stage can take a new header when it is empty or is being drained now.
    assign free_s  = !valid_r || ready_i;
    // Nothing is read while reset is asserted, so a pending latch is never lost.
    assign grant_s = !rst && free_s && found_s;
    assign load_s  = grant_s && !drop_s;

`ifdef HDR_ARB_DROP_EN
    assign drop_s = grant_s && (out_port_i[win_s] == {`NUM_PORTS{1'b0}});
`else
    assign drop_s = 1'b0;
`endif

    // Round-robin search: the first non-empty latch starting at the pointer, with wrap.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            cand_s = {1'b0, ptr_r} + (ID_W+1)'(i);
            if (cand_s >= NP_W) begin
                cand_s = cand_s - NP_W;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && !empty_i[cand_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot read pulse to the granted latch; silent otherwise.
    always_comb begin
        rd_o = '0;
        if (grant_s) begin
            rd_o[win_s] = 1'b1;
        end else begin
            rd_o = '0;
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= 1'b0;
            out_port_r <= '0;
            src_id_r   <= '0;
            ptr_r      <= '0;
            for (int b = 0; b < `HDR_MAX_LEN; b++) begin
                pkt_hdr_r[b] <= `ZERO_BYTE;
            end
        end else begin
            if (load_s) begin
                valid_r    <= 1'b1;
                pkt_hdr_r  <= pkt_hdr_i[win_s];
                out_port_r <= out_port_i[win_s];
                src_id_r   <= win_s;
            end else if (ready_i) begin
                // The consumer took the header and nothing replaces it; the data registers keep their old contents.
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (grant_s) begin
                ptr_r <= (win_s == ID_W'(NUM_PROCS - 1)) ? '0 : win_s + ID_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

`ifdef HDR_ARB_DROP_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of zero-mask headers that were read and discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt_o = drop_cnt_r;
`else
    assign drop_cnt_o = 16'h0000;
`endif

    assign valid_o    = valid_r;
    assign pkt_hdr_o  = pkt_hdr_r;
    assign out_port_o = out_port_r;
    assign src_id_o   = src_id_r;

endmodule

// File: tb/tb_hdr_rr_arbiter.sv
// Testbench for hdr_rr_arbiter. The bench models the source latches and
// drives them from a refill model. A reference model predicts read pulses and
// the contents of the output stage. Expected headers go into a scoreboard
// queue, and a monitor compares each one when the consumer accepts it.

`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 4
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef NUM_PORTS
`define NUM_PORTS 8
`endif

module tb_hdr_rr_arbiter;

    localparam int NP  = 4;
    localparam int HL  = `HDR_MAX_LEN;
    localparam int BB  = `BYTE_BUS;
    localparam int NPT = `NUM_PORTS;
    localparam int IDW = 2;

    logic                              clk;
    logic                              rst;
    logic [NP-1:0]                     empty_i;
    logic [0:NP-1][0:HL-1][BB-1:0]     pkt_hdr_i;
    logic [0:NP-1][NPT-1:0]            out_port_i;
    logic [NP-1:0]                     rd_o;
    logic                              valid_o;
    logic                              ready_i;
    logic [0:HL-1][BB-1:0]             pkt_hdr_o;
    logic [NPT-1:0]                    out_port_o;
    logic [IDW-1:0]                    src_id_o;
    logic [15:0]                       drop_cnt_o;

    hdr_rr_arbiter #(.NUM_PROCS(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .empty_i    (empty_i),
        .pkt_hdr_i  (pkt_hdr_i),
        .out_port_i (out_port_i),
        .rd_o       (rd_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .pkt_hdr_o  (pkt_hdr_o),
        .out_port_o (out_port_o),
        .src_id_o   (src_id_o),
        .drop_cnt_o (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [HL*BB-1:0] hdr;
        logic [NPT-1:0]   port;
        logic [IDW-1:0]   src;
    } item_t;

    item_t         exp_q[$];
    int            cmp_cnt = 0;
    int            err_cnt = 0;
    logic [NP-1:0] full;
    logic [NP-1:0] just_read;
    int            m_ptr;
    bit            m_valid;
    int            m_cnt;
    bit            done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Refill empty latches with a given chance. A latch read in the last cycle stays empty for one cycle.
    task automatic refill(input int pct);
        for (int k = 0; k < NP; k++) begin
            if (!full[k] && !just_read[k] && ($urandom_range(99) < pct)) begin
                full[k]          = 1'b1;
                pkt_hdr_i[k]     = (HL*BB)'({$urandom(), $urandom()});
                out_port_i[k]    = ($urandom_range(3) == 0) ? '0 : NPT'($urandom());
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, predict, check rd_o, then check registered state after the edge.
    task automatic step(input bit r, input bit rdy);
        logic [NP-1:0] exp_rd;
        int            g;
        bit            drop;
        item_t         it;
        rst       = r;
        ready_i   = rdy;
        empty_i   = ~full;
        exp_rd    = '0;
        just_read = '0;
        if (r) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_cnt   = 0;
            exp_q.delete();
        end else begin
            g = -1;
            for (int i = 0; i < NP; i++) begin
                if (g < 0 && full[(m_ptr + i) % NP]) g = (m_ptr + i) % NP;
            end
            if ((!m_valid || rdy) && g >= 0) begin
                exp_rd[g]    = 1'b1;
                just_read[g] = 1'b1;
                m_ptr        = (g + 1) % NP;
                drop         = 1'b0;
`ifdef HDR_ARB_DROP_EN
                drop = (out_port_i[g] == '0);
`endif
                if (drop) begin
                    if (m_cnt < 65535) m_cnt++;
                    m_valid = 1'b0;
                end else begin
                    it.hdr  = pkt_hdr_i[g];
                    it.port = out_port_i[g];
                    it.src  = IDW'(g);
                    exp_q.push_back(it);
                    m_valid = 1'b1;
                end
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("rd_o", 64'(rd_o), 64'(exp_rd));
        @(negedge clk);
        full = full & ~just_read;
        chk("valid_o", 64'(valid_o), 64'(m_valid));
        chk("drop_cnt_o", 64'(drop_cnt_o), 64'(m_cnt));
    endtask

    // Monitor: each accepted header is popped from the scoreboard and compared.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (!rst && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected output", 64'(valid_o), 64'd0);
                end else begin
                    it = exp_q.pop_front();
                    chk("pkt_hdr_o", 64'(pkt_hdr_o), 64'(it.hdr));
                    chk("out_port_o", 64'(out_port_o), 64'(it.port));
                    chk("src_id_o", 64'(src_id_o), 64'(it.src));
                end
            end
        end
    end

    initial begin
        logic [HL*BB-1:0] h0;
        logic [NPT-1:0]   p0;
        logic [IDW-1:0]   s0;
        rst        = 1'b1;
        ready_i    = 1'b1;
        full       = '0;
        just_read  = '0;
        empty_i    = '1;
        pkt_hdr_i  = '0;
        out_port_i = '0;
        m_ptr      = 0;
        m_valid    = 1'b0;
        m_cnt      = 0;
        @(negedge clk);

        // Reset with every latch full: no reads, outputs at reset values.
        refill(100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("reset pkt_hdr_o", 64'(pkt_hdr_o), 64'd0);
        chk("reset out_port_o", 64'(out_port_o), 64'd0);
        chk("reset src_id_o", 64'(src_id_o), 64'd0);

        // Fairness: keep every latch topped up; grants rotate 0,1,2,3,0,1,2.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            if (i == 0) chk("first grant src", 64'(src_id_o), 64'd0);
            refill(100);
        end

        // Single source, latch 2.
        step(1'b1, 1'b1);
        full          = 4'b0100;
        out_port_i[2] = 8'h04;
        step(1'b0, 1'b1);
        chk("single src_id", 64'(src_id_o), 64'd2);
        chk("single out_port", 64'(out_port_o), 64'h04);
        step(1'b0, 1'b1);

        // Backpressure: hold the stage for 5 cycles while latches 1 and 3 are full.
        full = 4'b1010;
        step(1'b0, 1'b1);
        full[3]      = 1'b1;
        pkt_hdr_i[3] = (HL*BB)'($urandom());
        h0 = pkt_hdr_o;
        p0 = out_port_o;
        s0 = src_id_o;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk("stall pkt_hdr_o", 64'(pkt_hdr_o), 64'(h0));
            chk("stall out_port_o", 64'(out_port_o), 64'(p0));
            chk("stall src_id_o", 64'(src_id_o), 64'(s0));
        end
        step(1'b0, 1'b1);
        chk("release src_id", 64'(src_id_o), 64'd1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Zero port mask from latch 1.
        step(1'b1, 1'b1);
        full          = 4'b0010;
        out_port_i[1] = '0;
        step(1'b0, 1'b1);
`ifndef HDR_ARB_DROP_EN
        chk("zero mask src_id", 64'(src_id_o), 64'd1);
        chk("zero mask out_port", 64'(out_port_o), 64'd0);
`endif
        step(1'b0, 1'b1);

        // Reset while a header is stalled in the stage.
        full          = 4'b0001;
        out_port_i[0] = 8'h81;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        full = 4'b1110;
        step(1'b1, 1'b0);
        full = 4'b1111;
        step(1'b0, 1'b1);
        chk("post-reset src_id", 64'(src_id_o), 64'd0);

        // Randomized traffic with occasional resets and backpressure.
        for (int i = 0; i < 400; i++) begin
            refill(40);
            step(($urandom_range(49) == 0), ($urandom_range(3) != 0));
        end

        done = 1'b1;
        #3;
        chk("queue depth", 64'(exp_q.size()), 64'(valid_o));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
